// File: rtl/fsm_channel_scheduler.sv
// Round-robin scheduler sharing one A-F sequence detector
// next-state datapath across NUM_CH channels.
module fsm_channel_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  en,
  input  logic [NUM_CH-1:0]     clr,
  input  logic [NUM_CH-1:0]     req_valid,
  input  logic [NUM_CH-1:0]     req_w,
  output logic [NUM_CH-1:0]     req_ready,
  output logic                  out_valid,
  output logic [CH_W-1:0]       out_ch,
  output logic [2:0]            out_state,
  output logic                  out_z,
  output logic [3*NUM_CH-1:0]   state_flat
);

  typedef enum logic [2:0] {
    ST_A = 3'd0,
    ST_B = 3'd1,
    ST_C = 3'd2,
    ST_D = 3'd3,
    ST_E = 3'd4,
    ST_F = 3'd5
  } st_e;

  function automatic logic [2:0] nxt(
    input logic [2:0] s,
    input logic       w
  );
    case (s)
      ST_A:    nxt = w ? ST_A : ST_B;
      ST_B:    nxt = w ? ST_D : ST_C;
      ST_C:    nxt = w ? ST_D : ST_E;
      ST_D:    nxt = w ? ST_A : ST_F;
      ST_E:    nxt = w ? ST_D : ST_E;
      ST_F:    nxt = w ? ST_D : ST_C;
      default: nxt = ST_A;
    endcase
  endfunction

  logic [2:0]        st [NUM_CH];
  logic [CH_W-1:0]   rr;
  logic [NUM_CH-1:0] elig;
  logic              gnt;
  logic [CH_W-1:0]   gidx;
  logic [CH_W:0]     idx;
  logic [CH_W-1:0]   rr_nxt;
  logic [2:0]        ns;
  logic              nz;

  // Reset also blanks eligibility so req_ready stays low during reset.
  assign elig = {NUM_CH{en & ~areset}} & req_valid & ~clr;

  always_comb begin
    gnt  = 1'b0;
    gidx = '0;
    idx  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = {1'b0, rr} + (CH_W+1)'(k);
      if (idx >= (CH_W+1)'(NUM_CH))
        idx = idx - (CH_W+1)'(NUM_CH);
      if (!gnt && elig[idx[CH_W-1:0]]) begin
        gnt  = 1'b1;
        gidx = idx[CH_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (gnt)
      req_ready[gidx] = 1'b1;
  end

  assign rr_nxt = (gidx == CH_W'(NUM_CH-1)) ?
                  '0 : gidx + CH_W'(1);
  assign ns     = nxt(st[gidx], req_w[gidx]);
  assign nz     = (ns == ST_E) || (ns == ST_F);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NUM_CH; i++)
        st[i] <= ST_A;
      rr <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (clr[i])
          st[i] <= ST_A;
        else if (gnt && gidx == CH_W'(i))
          st[i] <= ns;
      end
      if (gnt)
        rr <= rr_nxt;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_state <= 3'b000;
      out_z     <= 1'b0;
    end else begin
      out_valid <= gnt;
      if (gnt) begin
        out_ch    <= gidx;
        out_state <= ns;
        out_z     <= nz;
      end
    end
  end

  always_comb begin
    state_flat = '0;
    for (int i = 0; i < NUM_CH; i++)
      state_flat[3*i +: 3] = st[i];
  end

endmodule

// File: tb/tb_fsm_channel_scheduler.sv
// Scoreboard bench for fsm_channel_scheduler: queue-based
// reference model, random and directed stimulus.
module tb_fsm_channel_scheduler;
  localparam int N  = 4;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            areset;
  logic            en;
  logic [N-1:0]    clr;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_w;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [CW-1:0]   out_ch;
  logic [2:0]      out_state;
  logic            out_z;
  logic [3*N-1:0]  state_flat;

  always #5 clk = ~clk;

  fsm_channel_scheduler #(.NUM_CH(N)) dut (
    .clk(clk),
    .areset(areset),
    .en(en),
    .clr(clr),
    .req_valid(req_valid),
    .req_w(req_w),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_ch(out_ch),
    .out_state(out_state),
    .out_z(out_z),
    .state_flat(state_flat)
  );

  typedef struct {
    bit v;
    int ch;
    int st;
    bit z;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Transition table from the detector definition (index = state).
  int t0[8] = '{1, 2, 4, 5, 4, 2, 0, 0};
  int t1[8] = '{0, 3, 3, 0, 3, 3, 0, 0};

  int ms[N];
  int ptr;
  bit pend[N];
  bit pw[N];
  int lch;
  int lst;
  bit lz;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) ms[i] = 0;
    ptr = 0;
    lch = 0;
    lst = 0;
    lz  = 1'b0;
    q.delete();
  endtask

  task automatic rst_checks(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 0);
    check({tag, "_ch"},    32'(out_ch),    0);
    check({tag, "_state"}, 32'(out_state), 0);
    check({tag, "_z"},     32'(out_z),     0);
    check({tag, "_ready"}, 32'(req_ready), 0);
    check({tag, "_flat"},  32'(state_flat), 0);
  endtask

  task automatic step(input bit e,
                      input logic [N-1:0] c,
                      input bit gen);
    int           g;
    logic [N-1:0] er;
    logic [3*N-1:0] ef;
    exp_t         x;
    @(negedge clk);
    if (gen)
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          pw[i]   = 1'($urandom_range(0, 1));
        end
    en  = e;
    clr = c;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pend[i];
      req_w[i] = pend[i] ? pw[i] : 1'($urandom_range(0, 1));
    end
    #1;
    g = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (ptr + k) % N;
      if (g < 0 && e && pend[j] && !c[j]) g = j;
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(er));
    for (int i = 0; i < N; i++) ef[3*i +: 3] = ms[i][2:0];
    check("state_flat", 32'(state_flat), 32'(ef));
    if (g >= 0) begin
      ms[g]   = pw[g] ? t1[ms[g]] : t0[ms[g]];
      ptr     = (g + 1) % N;
      lch     = g;
      lst     = ms[g];
      lz      = (lst == 4) || (lst == 5);
      pend[g] = 1'b0;
    end
    for (int i = 0; i < N; i++)
      if (c[i]) ms[i] = 0;
    x.v  = (g >= 0);
    x.ch = lch;
    x.st = lst;
    x.z  = lz;
    q.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    areset = 1'b1;
    #1;
    rst_checks("midrst");
    model_reset();
    @(negedge clk);
    en     = 1'b0;
    clr    = '0;
    areset = 1'b0;
  endtask

  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (!areset) begin
        if (q.size() == 0) begin
          check("idle_valid", 32'(out_valid), 0);
        end else begin
          x = q.pop_front();
          check("out_valid", 32'(out_valid), 32'(x.v));
          check("out_ch",    32'(out_ch),    32'(x.ch));
          check("out_state", 32'(out_state), 32'(x.st));
          check("out_z",     32'(out_z),     32'(x.z));
        end
      end
    end
  end

  initial begin
    int wseq[5] = '{0, 0, 0, 1, 0};
    logic [N-1:0] c;
    areset    = 1'b1;
    en        = 1'b1;
    clr       = '0;
    req_valid = '1;
    req_w     = '0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      pw[i]   = 1'b0;
    end
    model_reset();
    #2;
    rst_checks("rst");
    @(negedge clk);
    en        = 1'b0;
    req_valid = '0;
    areset    = 1'b0;

    for (int s = 0; s < 5; s++) begin
      pend[0] = 1'b1;
      pw[0]   = wseq[s][0];
      step(1'b1, '0, 1'b0);
    end
    step(1'b0, '0, 1'b0);
    check("t1_ch0_F", 32'(state_flat[2:0]), 5);

    do_reset();
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < N; i++) pend[i] = 1'b1;
      step(1'b1, '0, 1'b0);
    end

    for (int s = 0; s < 6 && ms[2] != 4; s++) begin
      pend[2] = 1'b1;
      pw[2]   = 1'b0;
      step(1'b1, '0, 1'b0);
    end
    pend[2] = 1'b1;
    step(1'b1, 4'b0100, 1'b0);
    step(1'b0, '0, 1'b0);
    check("t4_clr", 32'(state_flat[8:6]), 0);

    for (int i = 0; i < N; i++) pend[i] = 1'b1;
    repeat (3) step(1'b0, '0, 1'b0);
    step(1'b1, '0, 1'b0);

    for (int i = 0; i < N; i++) pend[i] = 1'b1;
    step(1'b1, '0, 1'b0);
    do_reset();
    step(1'b1, '0, 1'b0);

    for (int s = 0; s < 500; s++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        c = '0;
        for (int i = 0; i < N; i++)
          if ($urandom_range(0, 7) == 0) c[i] = 1'b1;
        step($urandom_range(0, 7) != 0, c, 1'b1);
      end
    end

    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fsm_channel_scheduler.md
Name: fsm_channel_scheduler

Overview:
- Time-multiplexes one six-state sequence-detector next-state datapath (states A–F, input w, Moore output z) across NUM_CH independent channels.
- Holds a 3-bit state register per channel and arbitrates requesters round-robin.
- Applies one w-step per cycle to the granted channel and reports that channel's resulting state and z one cycle later.
- Sits between per-channel bit-serial sources and the downstream pattern-event consumer.

Parameters:
- NUM_CH, 4, number of channels (2..16).
- CH_W, $clog2(NUM_CH), width of channel index.

Ports:
- clk  in  1  system clock, rising edge
- areset  in  1  asynchronous, active-high reset
- en  in  1  global grant enable; 0 = no grants
- clr  in  NUM_CH  per-channel synchronous clear of state to A
- req_valid  in  NUM_CH  channel i presents a w bit
- req_w  in  NUM_CH  w bit for channel i
- req_ready  out  NUM_CH  one-hot grant; the w bit is consumed this cycle
- out_valid  out  1  result pulse
- out_ch  out  CH_W  channel index of result
- out_state  out  3  new state of that channel
- out_z  out  1  Moore output of new state
- state_flat  out  3*NUM_CH  all channel states, channel i at bits [3i+2:3i]

Behaviour:
- State encoding: A=000, B=001, C=010, D=011, E=100, F=101. z=1 in E and F only.
- Next-state function, written as (w=0 / w=1):
  - A: B / A
  - B: C / D
  - C: E / D
  - D: F / A
  - E: E / D
  - F: C / D
  - 110, 111: A / A (recovery)
- Reset (areset=1, immediate):
  - all channel states = A
  - rr pointer = 0
  - out_valid=0, out_ch=0, out_state=000, out_z=0
  - req_ready=0 while reset is asserted
- Eligibility: channel i is eligible when en & req_valid[i] & ~clr[i].
- Arbitration (combinational, same cycle):
  - Grant the first eligible channel searching upward from the rr pointer, wrapping at NUM_CH-1 to 0.
  - req_ready is one-hot on the granted channel, all-zero if none is eligible.
  - A request is consumed only in a cycle where its req_ready=1. A non-granted requester must hold req_valid and req_w.
- Update on a clock edge with a grant g:
  - state[g] <= next(state[g], req_w[g]).
  - rr pointer <= g+1, wrapping NUM_CH-1 to 0.
  - With no grant, the pointer holds.
- Output register (latency 1 cycle from grant):
  - out_valid <= grant_present.
  - out_ch, out_state, out_z are loaded with the granted channel's index, new state and z(new state) when a grant occurs; otherwise they hold their previous values.
- clr:
  - clr[i]=1 forces state[i] <= A at the next edge.
  - It also masks channel i from arbitration that cycle, so there is never a simultaneous update and clear.
  - Multiple clr bits may be set at once.
- en=0: no grants, out_valid=0 next cycle, states hold; clr is still honored.
- state_flat reflects the registered states (post-edge values, no bypass).
- areset mid-stream: any in-flight result is discarded and the pointer returns to 0; a request held across reset is granted again after reset releases.
- Fairness: with all channels continuously eligible, grants cycle 0,1,…,NUM_CH-1,0,…; every eligible channel is granted within NUM_CH cycles.

Test Plan:
1. Reset, then channel 0 only, w=0,0,0,1,0 over 5 grants → out_state B,C,E,D,F; out_z 0,0,1,0,1; out_ch=0; each output one cycle after its req_ready.
2. All 4 channels req_valid=1 for 8 cycles → req_ready sequence 0001,0010,0100,1000,0001,…; out_ch 0,1,2,3,0,1,2,3.
3. Pointer wrap/skip: pointer at 3, only channels 1 and 3 requesting → grant 3, then 1, then 3; channels 0 and 2 states unchanged in state_flat.
4. Channel 2 in E; assert clr[2] together with req_valid[2] → req_ready[2]=0, state[2]=A next cycle, no out_valid for channel 2.
5. en=0 for 3 cycles with all requests held → req_ready=0, out_valid=0, states frozen; on en=1 the grant resumes at the held pointer.
6. Drive channels to C/D/E/F, then pulse areset between edges → all states A and outputs zero immediately; first grant after release goes to channel 0.
